connect4_turn_ctrl: RTL and testbench

Turn sequencer for the Connect-4 game. It takes debounced single-cycle button pulses and a 1 Hz tick, and runs each turn end to end:
- moves the column cursor;
- finds the lowest empty cell in the chosen column;
- writes the current player's piece into the board store;
- hands off to the external win checker;
- advances the turn, or ends the game on win, draw, or per-turn timeout forfeit.

It sits between the button edge detectors and the board register file / win checker, on the VGA pixel clock domain.

---
 rtl/connect4_turn_ctrl.sv | 164 ++++++++++++++++
 tb/tb_connect4_turn_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : connect4_turn_ctrl
// Brief    : Connect-4 turn sequencer: cursor, column scan, board write,
//            win-check handoff, turn timer and game end.
// Revision : 1.0
// ============================================================================
module connect4_turn_ctrl #(
    parameter logic [3:0] TURN_TIME = 4'd10,
    parameter logic [2:0] START_COL = 3'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_made,
    input  logic       tick_1s,
    input  logic [1:0] rd_data,
    input  logic       check_done,
    input  logic       check_win,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       check_start,
    output logic [2:0] state,
    output logic       player_turn,
    output logic [2:0] cursor_col,
    output logic [3:0] time_left,
    output logic [5:0] move_count,
    output logic       col_full,
    output logic [1:0] winner,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_SELECT = 3'b000,
        S_SCAN   = 3'b001,
        S_WRITE  = 3'b010,
        S_CHECK  = 3'b011,
        S_NEXT   = 3'b100,
        S_WIN    = 3'b101,
        S_DRAW   = 3'b110
    } state_t;

    state_t     state_q;
    logic [2:0] rd_row_q, rd_col_q, wr_row_q, wr_col_q, cursor_col_q;
    logic [1:0] wr_data_q, winner_q;
    logic [3:0] time_left_q;
    logic [5:0] move_count_q;
    logic       wr_en_q, check_start_q, col_full_q, player_turn_q, game_over_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_SELECT;
            rd_row_q      <= 3'd5;
            rd_col_q      <= 3'd0;
            wr_row_q      <= 3'd0;
            wr_col_q      <= 3'd0;
            wr_data_q     <= 2'b01;
            wr_en_q       <= 1'b0;
            check_start_q <= 1'b0;
            col_full_q    <= 1'b0;
            player_turn_q <= 1'b0;
            cursor_col_q  <= START_COL;
            time_left_q   <= TURN_TIME;
            move_count_q  <= 6'd0;
            winner_q      <= 2'b00;
            game_over_q   <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            check_start_q <= 1'b0;
            col_full_q    <= 1'b0;
            case (state_q)
                S_SELECT: begin
                    if (move_made) begin
                        rd_col_q <= cursor_col_q;
                        rd_row_q <= 3'd5;
                        state_q  <= S_SCAN;
                    end else begin
                        if (move_left && !move_right && cursor_col_q != 3'd0)
                            cursor_col_q <= cursor_col_q - 3'd1;
                        else if (move_right && !move_left && cursor_col_q != 3'd6)
                            cursor_col_q <= cursor_col_q + 3'd1;
                        // Last second expiring forfeits the turn without a write.
                        if (tick_1s) begin
                            if (time_left_q <= 4'd1) begin
                                time_left_q <= 4'd0;
                                state_q     <= S_NEXT;
                            end else begin
                                time_left_q <= time_left_q - 4'd1;
                            end
                        end
                    end
                end
                S_SCAN: begin
                    if (rd_data == 2'b00) begin
                        wr_row_q  <= rd_row_q;
                        wr_col_q  <= rd_col_q;
                        wr_data_q <= player_turn_q ? 2'b10 : 2'b01;
                        wr_en_q   <= 1'b1;
                        state_q   <= S_WRITE;
                    end else if (rd_row_q != 3'd0) begin
                        rd_row_q <= rd_row_q - 3'd1;
                    end else begin
                        col_full_q <= 1'b1;
                        state_q    <= S_SELECT;
                    end
                end
                S_WRITE: begin
                    check_start_q <= 1'b1;
                    state_q       <= S_CHECK;
                end
                S_CHECK: begin
                    if (check_done) begin
                        if (check_win) begin
                            winner_q    <= {player_turn_q, ~player_turn_q};
                            game_over_q <= 1'b1;
                            state_q     <= S_WIN;
                        end else begin
                            move_count_q <= move_count_q + 6'd1;
                            if (move_count_q == 6'd41) begin
                                winner_q    <= 2'b11;
                                game_over_q <= 1'b1;
                                state_q     <= S_DRAW;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    end
                end
                S_NEXT: begin
                    player_turn_q <= ~player_turn_q;
                    cursor_col_q  <= START_COL;
                    time_left_q   <= TURN_TIME;
                    state_q       <= S_SELECT;
                end
                S_WIN, S_DRAW: begin
                end
                default: state_q <= S_SELECT;
            endcase
        end
    end

    assign rd_row      = rd_row_q;
    assign rd_col      = rd_col_q;
    assign wr_en       = wr_en_q;
    assign wr_row      = wr_row_q;
    assign wr_col      = wr_col_q;
    assign wr_data     = wr_data_q;
    assign check_start = check_start_q;
    assign state       = state_q;
    assign player_turn = player_turn_q;
    assign cursor_col  = cursor_col_q;
    assign time_left   = time_left_q;
    assign move_count  = move_count_q;
    assign col_full    = col_full_q;
    assign winner      = winner_q;
    assign game_over   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_connect4_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect4_turn_ctrl
// Brief    : Scoreboard bench for connect4_turn_ctrl with a board model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_connect4_turn_ctrl;

    logic       clk = 1'b0;
    logic       reset, move_left, move_right, move_made, tick_1s;
    logic       check_done, check_win;
    logic [1:0] rd_data;
    logic [2:0] rd_row, rd_col, wr_row, wr_col, state, cursor_col;
    logic [1:0] wr_data, winner;
    logic       wr_en, check_start, player_turn, col_full, game_over;
    logic [3:0] time_left;
    logic [5:0] move_count;

    always #5 clk = ~clk;

    connect4_turn_ctrl #(.TURN_TIME(4'd10), .START_COL(3'd3)) dut (
        .clk(clk), .reset(reset),
        .move_left(move_left), .move_right(move_right),
        .move_made(move_made), .tick_1s(tick_1s),
        .rd_data(rd_data), .check_done(check_done), .check_win(check_win),
        .rd_row(rd_row), .rd_col(rd_col),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .check_start(check_start), .state(state), .player_turn(player_turn),
        .cursor_col(cursor_col), .time_left(time_left), .move_count(move_count),
        .col_full(col_full), .winner(winner), .game_over(game_over)
    );

    typedef struct packed {
        logic       kind;   // 0 = board write, 1 = rejected drop
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] board [42];
    int         height [7];
    int         m_player, m_cur, m_moves;

    assign rd_data = (rd_row <= 3'd5 && rd_col <= 3'd6) ?
                     board[int'(rd_row) * 7 + int'(rd_col)] : 2'b00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (wr_en || col_full) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: wr_en=%0b col_full=%0b with nothing expected",
                             wr_en, col_full);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == 1'b0 &&
                        !(wr_en && !col_full && wr_row == e.row && wr_col == e.col && wr_data == e.data)) begin
                        errors++;
                        $display("FAIL write_event: got wr_en=%0b row=%0d col=%0d data=%0d expected row=%0d col=%0d data=%0d",
                                 wr_en, wr_row, wr_col, wr_data, e.row, e.col, e.data);
                    end else if (e.kind == 1'b1 && !(col_full && !wr_en && rd_col == e.col)) begin
                        errors++;
                        $display("FAIL col_full_event: got col_full=%0b wr_en=%0b col=%0d expected col_full=1 col=%0d",
                                 col_full, wr_en, rd_col, e.col);
                    end
                end
                if (wr_en) board[int'(wr_row) * 7 + int'(wr_col)] = wr_data;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r, input logic m, input logic t);
        move_left = l; move_right = r; move_made = m; tick_1s = t;
        step();
        move_left = 0; move_right = 0; move_made = 0; tick_1s = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 42; i++) board[i] = 2'b00;
        for (int c = 0; c < 7; c++) height[c] = 0;
        m_player = 0; m_cur = 3; m_moves = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_reset_vals();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_player", 8'(player_turn), 8'd0);
        chk("rst_cursor", 8'(cursor_col), 8'd3);
        chk("rst_time_left", 8'(time_left), 8'd10);
        chk("rst_move_count", 8'(move_count), 8'd0);
        chk("rst_winner", 8'(winner), 8'd0);
        chk("rst_game_over", 8'(game_over), 8'd0);
        chk("rst_wr_en", 8'(wr_en), 8'd0);
        chk("rst_check_start", 8'(check_start), 8'd0);
        chk("rst_col_full", 8'(col_full), 8'd0);
        chk("rst_rd_row", 8'(rd_row), 8'd5);
        chk("rst_rd_col", 8'(rd_col), 8'd0);
        chk("rst_wr_row", 8'(wr_row), 8'd0);
        chk("rst_wr_col", 8'(wr_col), 8'd0);
        chk("rst_wr_data", 8'(wr_data), 8'd1);
    endtask

    task automatic goto_col(input int c);
        while (m_cur > c) begin press(1, 0, 0, 0); m_cur--; end
        while (m_cur < c) begin press(0, 1, 0, 0); m_cur++; end
    endtask

    // Full turn: aim, drop, answer the win checker, step into the next turn.
    task automatic drop(input int c, input logic win);
        int n;
        goto_col(c);
        exp_q.push_back({1'b0, 3'(5 - height[c]), 3'(c), (m_player != 0) ? 2'b10 : 2'b01});
        press(0, 0, 1, 0);
        n = 0;
        while (!check_start && n < 20) begin step(); n++; end
        chk("check_start_seen", 8'(check_start), 8'd1);
        check_done = 1'b1; check_win = win;
        step();
        check_done = 1'b0; check_win = 1'b0;
        height[c]++;
        if (!win) begin
            m_moves++;
            if (m_moves < 42) begin
                step();
                m_player ^= 1;
                m_cur = 3;
            end
        end
    endtask

    initial begin
        int n, p;
        reset = 0; move_left = 0; move_right = 0; move_made = 0; tick_1s = 0;
        check_done = 0; check_win = 0;
        clear_model();
        fork monitor_loop(); join_none

        do_reset();
        check_reset_vals();

        // First drop into column 3 with cycle-accurate latency checks.
        exp_q.push_back({1'b0, 3'd5, 3'd3, 2'b01});
        press(0, 0, 1, 0);
        chk("drop_scan_state", 8'(state), 8'd1);
        chk("drop_rd_col", 8'(rd_col), 8'd3);
        chk("drop_rd_row", 8'(rd_row), 8'd5);
        step();
        chk("drop_wr_en", 8'(wr_en), 8'd1);
        chk("drop_write_state", 8'(state), 8'd2);
        step();
        chk("drop_check_start", 8'(check_start), 8'd1);
        chk("drop_check_state", 8'(state), 8'd3);
        step();
        chk("check_waits", 8'(state), 8'd3);
        check_done = 1'b1;
        step();
        check_done = 1'b0;
        chk("next_state", 8'(state), 8'd4);
        step();
        chk("turn_state", 8'(state), 8'd0);
        chk("turn_player", 8'(player_turn), 8'd1);
        chk("turn_move_count", 8'(move_count), 8'd1);
        chk("turn_time_left", 8'(time_left), 8'd10);
        chk("turn_cursor", 8'(cursor_col), 8'd3);
        height[3] = 1; m_moves = 1; m_player = 1; m_cur = 3;

        // Cursor saturation and simultaneous buttons.
        for (int i = 0; i < 4; i++) begin
            press(1, 0, 0, 0);
            chk("cursor_left", 8'(cursor_col), 8'((i < 3) ? (2 - i) : 0));
        end
        for (int i = 0; i < 8; i++) begin
            press(0, 1, 0, 0);
            chk("cursor_right", 8'(cursor_col), 8'((i < 6) ? (i + 1) : 6));
        end
        press(1, 1, 0, 0);
        chk("cursor_both", 8'(cursor_col), 8'd6);
        m_cur = 6;

        // Fill column 0, then a rejected drop into it.
        for (int k = 0; k < 6; k++) drop(0, 1'b0);
        goto_col(0);
        p = m_player;
        exp_q.push_back({1'b1, 3'd0, 3'd0, 2'b00});
        press(0, 0, 1, 0);
        n = 0;
        while (state == 3'd1 && n < 20) begin step(); n++; end
        chk("full_scan_cycles", 8'(n), 8'd6);
        chk("full_state", 8'(state), 8'd0);
        chk("full_pulse", 8'(col_full), 8'd1);
        chk("full_player", 8'(player_turn), 8'(p));
        chk("full_cursor", 8'(cursor_col), 8'd0);
        chk("full_move_count", 8'(move_count), 8'd7);
        step();
        chk("full_pulse_one_cycle", 8'(col_full), 8'd0);

        // Timeout forfeit.
        for (int i = 1; i <= 9; i++) begin
            press(0, 0, 0, 1);
            chk("tick_time_left", 8'(time_left), 8'(10 - i));
        end
        press(0, 0, 0, 1);
        chk("forfeit_zero", 8'(time_left), 8'd0);
        chk("forfeit_next", 8'(state), 8'd4);
        step();
        chk("forfeit_select", 8'(state), 8'd0);
        chk("forfeit_reload", 8'(time_left), 8'd10);
        chk("forfeit_player", 8'(player_turn), 8'(p ^ 1));
        chk("forfeit_moves", 8'(move_count), 8'd7);
        chk("forfeit_cursor", 8'(cursor_col), 8'd3);
        m_player ^= 1; m_cur = 3;

        // Player 1 wins; game stays frozen until reset.
        drop(6, 1'b0);
        chk("win_player_before", 8'(player_turn), 8'd1);
        drop(5, 1'b1);
        chk("win_state", 8'(state), 8'd5);
        chk("win_winner", 8'(winner), 8'd2);
        chk("win_game_over", 8'(game_over), 8'd1);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        step(); step();
        chk("win_absorb_state", 8'(state), 8'd5);
        chk("win_absorb_time", 8'(time_left), 8'd10);
        chk("win_absorb_cursor", 8'(cursor_col), 8'd5);
        chk("win_absorb_moves", 8'(move_count), 8'd8);
        chk("win_absorb_winner", 8'(winner), 8'd2);
        chk("queue_drained_win", 8'(exp_q.size()), 8'd0);
        do_reset();
        check_reset_vals();

        // Full board without a winner.
        for (int c = 0; c < 7; c++)
            for (int k = 0; k < 6; k++) drop(c, 1'b0);
        chk("draw_state", 8'(state), 8'd6);
        chk("draw_winner", 8'(winner), 8'd3);
        chk("draw_game_over", 8'(game_over), 8'd1);
        chk("draw_moves", 8'(move_count), 8'd42);
        press(0, 0, 1, 0);
        step();
        chk("draw_absorb", 8'(state), 8'd6);

        // Reset in the middle of a scan drops the pending write.
        do_reset();
        for (int k = 0; k < 3; k++) drop(3, 1'b0);
        press(0, 0, 1, 0);
        step();
        chk("midscan_state", 8'(state), 8'd1);
        chk("midscan_rd_row", 8'(rd_row), 8'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midscan_rst_state", 8'(state), 8'd0);
        chk("midscan_rst_wr_en", 8'(wr_en), 8'd0);
        chk("midscan_rst_rd_row", 8'(rd_row), 8'd5);
        chk("midscan_rst_player", 8'(player_turn), 8'd0);
        chk("midscan_rst_moves", 8'(move_count), 8'd0);
        for (int i = 0; i < 8; i++) step();
        chk("midscan_idle_state", 8'(state), 8'd0);
        chk("queue_drained_end", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
